// File: rtl/add_share_arbiter_pkg.sv
// Shared types for the add_share_arbiter block: FSM state encoding and
// helper for sizing requester-index fields.
package add_share_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  // Index width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward
// from the one after last_grant, wrapping around.
import add_share_pkg::*;

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_valid
);

  // Rotating priority scan; the first hit wins, later hits are ignored.
  always_comb begin
    logic             found;
    logic [ID_W-1:0]  cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(last_grant) + k) % 32'(NUM_REQ));
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign any_valid = |valid;

endmodule

// File: rtl/add_share_arbiter.sv
// Shares one registered W-bit adder among NUM_REQ requesters. Round-robin
// grant in IDLE, add in EXEC, hold tagged result in RESP until accepted.
import add_share_pkg::*;

module add_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W       = 4,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*W-1:0]         req_a,
  input  logic [NUM_REQ*W-1:0]         req_b,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [W:0]                   rsp_sum,
  output logic [id_width(NUM_REQ)-1:0] rsp_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             op_count
);

  localparam int ID_W = id_width(NUM_REQ);

  typedef logic [W:0] sum_t;

  state_t           state;
  logic [ID_W-1:0]  last_grant;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [ID_W-1:0]  id_q;
  sum_t             sum_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_valid_q;
  logic             busy_q;
  logic [CNT_W-1:0] op_count_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (pick_grant),
    .grant_idx  (pick_idx),
    .any_valid  (pick_any)
  );

  // Accept strobe only in IDLE and never while reset is asserted.
  assign req_ready = (state == IDLE && !rst) ? pick_grant : '0;

  // Control FSM with registered response, status and counter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= ID_W'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            a_q        <= req_a[int'(pick_idx)*W +: W];
            b_q        <= req_b[int'(pick_idx)*W +: W];
            id_q       <= pick_idx;
            last_grant <= pick_idx;
            busy_q     <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // rsp_id is reloaded here, not at grant, so it stays paired with sum_q.
          sum_q       <= {1'b0, a_q} + {1'b0, b_q};
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count_q  <= op_count_q + CNT_W'(1);
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign op_count  = op_count_q;

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one registered W-bit adder among NUM_REQ requesters.
- Each requester offers an (a, b) operand pair over a valid/ready handshake. A round-robin arbiter grants one requester at a time and launches the addition.
- The W+1-bit sum returns on a single response channel, tagged with the requester ID. Used to serialise add tasks from stimulus generators onto one datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- W, 4, operand width; sum width is W+1.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept strobe (at most one bit high).
- req_a  in  NUM_REQ*W  packed operand a; slice i belongs to requester i.
- req_b  in  NUM_REQ*W  packed operand b; slice i belongs to requester i.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  W+1  a+b, zero-extended, no truncation.
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns rsp_sum.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  number of completed responses; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk.
- FSM states: IDLE, EXEC, RESP.
- IDLE, winner selection:
  - If any req_valid is high, the winner g is the first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping.
  - req_ready[g] = 1 combinationally in the same cycle. The handshake completes that cycle.
  - On that edge: capture a_q, b_q and id_q from slice g; set last_grant = g; go to EXEC.
- IDLE, no request: stay in IDLE. req_ready is all zeros.
- EXEC: sum_q <= a_q + b_q at W+1 bits (carry kept); go to RESP. req_ready is all zeros.
- RESP:
  - rsp_valid = 1. rsp_sum and rsp_id are stable from registers.
  - When rsp_ready is high: op_count increments (wraps at all-ones to 0) and the FSM returns to IDLE.
  - When rsp_ready is low: hold rsp_valid, rsp_sum and rsp_id unchanged, with no limit.
- Latency: handshake at edge T gives rsp_valid high from cycle T+2. Minimum spacing between accepts is 3 cycles.
- req_ready is asserted only in IDLE. It is never asserted to more than one requester, and never while rsp_valid is high.
- Requester rules: a requester must hold req_valid, req_a and req_b stable until its req_ready is seen. Dropping req_valid before the grant is legal and simply removes it from arbitration.
- A requester that keeps req_valid high is served again only after all other valid requesters have been served once (fairness).
- Simultaneous request and response completion: no overlap. A new grant is evaluated in the IDLE cycle following the RESP handshake.
- Reset, at any time including mid-EXEC or mid-RESP:
  - state = IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority after reset.
  - rsp_valid = 0, rsp_sum = 0, rsp_id = 0, op_count = 0, busy = 0.
  - req_ready is forced to 0 while rst is high.
  - Any in-flight operation is discarded with no response.
- Outputs are X-free after the first reset edge. rsp_sum and rsp_id keep their last value in IDLE and are qualified only by rsp_valid.

Decomposition:
- Package add_share_pkg: state enum (IDLE, EXEC, RESP); localparam ID_W = $clog2(NUM_REQ); typedef for the sum, logic [W:0].
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: valid vector and last_grant.
  - Outputs: one-hot grant, grant index, any_valid.
  - Instantiated once. Keeps the FSM file free of priority logic.

Test Plan:
- Single request: rst released; req_valid=4'b0001, a=1, b=3 → req_ready[0] for one cycle; two cycles later rsp_valid=1, rsp_sum=4, rsp_id=0; op_count=1 after the rsp_ready handshake.
- Overflow: requester 2 sends a=15, b=15 → rsp_sum=30 (5'b11110), rsp_id=2, no truncation.
- Fairness: all four req_valid held high with distinct operands (5+6, 7+8, 1+1, 0+15) → grant order 0,1,2,3, then 0 again; sums 11, 15, 2, 15 in that order.
- Backpressure: rsp_ready low for 10 cycles during RESP → rsp_valid, rsp_sum and rsp_id constant; req_ready stays 0 for all requesters; op_count unchanged until release.
- Reset mid-operation: assert rst in EXEC → next cycle state IDLE, rsp_valid=0, op_count=0; with all requesters still valid, the first grant goes to requester 0.
- Counter wrap: with CNT_W=4, complete 17 operations → op_count reads 1.
